// File: rtl/rmt_pkg.sv
// Shared RMT stage definitions: container geometry, PHV layout offsets and the
// packed PHV payload used by the stage-entry crossbar and the ALU-output assembler.
package rmt_pkg;

    localparam int unsigned NUM_CONT        = 8;
    localparam int unsigned CONT_6B_W       = 48;
    localparam int unsigned CONT_4B_W       = 32;
    localparam int unsigned CONT_2B_W       = 16;
    localparam int unsigned META_W          = 256;

    localparam int unsigned BUS_6B_W        = NUM_CONT * CONT_6B_W;
    localparam int unsigned BUS_4B_W        = NUM_CONT * CONT_4B_W;
    localparam int unsigned BUS_2B_W        = NUM_CONT * CONT_2B_W;
    localparam int unsigned PHV_W           = BUS_6B_W + BUS_4B_W + BUS_2B_W + META_W;

    localparam int unsigned DISCARD_BIT_DEF = 128;

    // Field offsets inside the PHV, metadata at the LSBs and 6B containers at the MSBs.
    localparam int unsigned OFF_META        = 0;
    localparam int unsigned OFF_2B          = OFF_META + META_W;
    localparam int unsigned OFF_4B          = OFF_2B + BUS_2B_W;
    localparam int unsigned OFF_6B          = OFF_4B + BUS_4B_W;

    typedef struct packed {
        logic [BUS_6B_W-1:0] c6;
        logic [BUS_4B_W-1:0] c4;
        logic [BUS_2B_W-1:0] c2;
        logic [META_W-1:0]   meta;
    } phv_t;

    function automatic phv_t pack_phv(
        input logic [BUS_6B_W-1:0] c6,
        input logic [BUS_4B_W-1:0] c4,
        input logic [BUS_2B_W-1:0] c2,
        input logic [META_W-1:0]   meta
    );
        phv_t p;
        p.c6   = c6;
        p.c4   = c4;
        p.c2   = c2;
        p.meta = meta;
        return p;
    endfunction

endpackage

// File: rtl/phv_skid_fifo.sv
// Two-entry registered FIFO with valid/ready on both sides; output is forced to
// zero while empty so reset leaves a clean bus regardless of stale storage.
module phv_skid_fifo #(
    parameter int unsigned DATA_W = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              push;
    logic              pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; 1-bit pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    // Storage carries no reset; contents are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/phv_assembler.sv
// ALU-output packer: rebuilds the PHV from per-size result buses plus metadata,
// filters discarded PHVs, buffers two entries and keeps saturating statistics.
module phv_assembler
    import rmt_pkg::*;
#(
    parameter int unsigned STAGE_ID    = 0,
    parameter int unsigned PHV_LEN     = PHV_W,
    parameter int unsigned width_6B    = CONT_6B_W,
    parameter int unsigned width_4B    = CONT_4B_W,
    parameter int unsigned width_2B    = CONT_2B_W,
    parameter int unsigned DISCARD_BIT = DISCARD_BIT_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_out_valid,
    input  logic [NUM_CONT*width_6B-1:0] alu_out_6B,
    input  logic [NUM_CONT*width_4B-1:0] alu_out_4B,
    input  logic [NUM_CONT*width_2B-1:0] alu_out_2B,
    input  logic [META_W-1:0]            phv_remain_data,
    output logic                         ready_out,
    output logic [PHV_LEN-1:0]           phv_out,
    output logic                         phv_out_valid,
    input  logic                         ready_in,
    output logic [CNT_W-1:0]             phv_out_cnt,
    output logic [CNT_W-1:0]             phv_drop_cnt,
    output logic [CNT_W-1:0]             stall_cnt
);

    // Elaboration guards: layout must match the shared PHV geometry.
    if (PHV_LEN != PHV_W) begin : g_bad_len
        $error("phv_assembler: PHV_LEN does not match container layout");
    end
    if (DISCARD_BIT >= META_W) begin : g_bad_discard
        $error("phv_assembler: DISCARD_BIT outside metadata");
    end
    if (STAGE_ID > 255) begin : g_bad_stage
        $error("phv_assembler: STAGE_ID out of range");
    end

    phv_t       entry;
    logic       discard;
    logic       accept;
    logic       keep;
    logic       pop;
    logic       stall;
    logic [1:0] fifo_count;

    assign entry   = pack_phv(alu_out_6B, alu_out_4B, alu_out_2B, phv_remain_data);
    assign discard = phv_remain_data[DISCARD_BIT];
    assign accept  = alu_out_valid & ready_out;
    assign keep    = alu_out_valid & ~discard;
    assign pop     = phv_out_valid & ready_in;
    assign stall   = (fifo_count != 2'd0) & ~ready_in;

    phv_skid_fifo #(
        .DATA_W(PHV_LEN)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (keep),
        .in_ready (ready_out),
        .in_data  (PHV_LEN'(entry)),
        .out_valid(phv_out_valid),
        .out_ready(ready_in),
        .out_data (phv_out),
        .count    (fifo_count)
    );

    // Statistics counters, each holding at all-ones once saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            phv_out_cnt  <= '0;
            phv_drop_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (pop && (phv_out_cnt != '1)) begin
                phv_out_cnt <= phv_out_cnt + CNT_W'(1);
            end
            if (accept && discard && (phv_drop_cnt != '1)) begin
                phv_drop_cnt <= phv_drop_cnt + CNT_W'(1);
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_phv_assembler.sv
// Randomized self-checking bench for phv_assembler against a queue-based model.
module tb_phv_assembler;

    localparam int unsigned PHV_LEN = 1024;

    logic               clk = 1'b0;
    logic               rst;
    logic               alu_out_valid;
    logic [383:0]       alu_out_6B;
    logic [255:0]       alu_out_4B;
    logic [127:0]       alu_out_2B;
    logic [255:0]       phv_remain_data;
    logic               ready_out;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic               ready_in;
    logic [31:0]        phv_out_cnt;
    logic [31:0]        phv_drop_cnt;
    logic [31:0]        stall_cnt;

    always #5 clk = ~clk;

    phv_assembler dut (
        .clk            (clk),
        .rst            (rst),
        .alu_out_valid  (alu_out_valid),
        .alu_out_6B     (alu_out_6B),
        .alu_out_4B     (alu_out_4B),
        .alu_out_2B     (alu_out_2B),
        .phv_remain_data(phv_remain_data),
        .ready_out      (ready_out),
        .phv_out        (phv_out),
        .phv_out_valid  (phv_out_valid),
        .ready_in       (ready_in),
        .phv_out_cnt    (phv_out_cnt),
        .phv_drop_cnt   (phv_drop_cnt),
        .stall_cnt      (stall_cnt)
    );

    // Reference model: a bounded queue of expected PHVs plus counters.
    logic [PHV_LEN-1:0] mq [$];
    logic [31:0]        m_out;
    logic [31:0]        m_drop;
    logic [31:0]        m_stall;
    bit                 last_acc;
    int                 checks = 0;
    int                 errors = 0;

    function automatic logic [PHV_LEN-1:0] rnd_phv(input bit discard);
        logic [PHV_LEN-1:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        v[128] = discard;
        return v;
    endfunction

    function automatic logic [PHV_LEN-1:0] m_head();
        if (mq.size() == 0) return '0;
        return mq[0];
    endfunction

    // Apply one cycle of stimulus at a negedge, advance the model, return at next negedge.
    task automatic step(input logic v, input logic [PHV_LEN-1:0] beat, input logic rdy);
        bit acc;
        bit pop;
        alu_out_valid   = v;
        alu_out_6B      = beat[1023:640];
        alu_out_4B      = beat[639:384];
        alu_out_2B      = beat[383:256];
        phv_remain_data = beat[255:0];
        ready_in        = rdy;
        acc = v && (mq.size() < 2);
        pop = (mq.size() > 0) && rdy;
        if ((mq.size() > 0) && !rdy && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
        if (pop) begin
            void'(mq.pop_front());
            if (m_out != 32'hFFFF_FFFF) m_out = m_out + 32'd1;
        end
        if (acc) begin
            if (beat[128]) begin
                if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
            end else begin
                mq.push_back(beat);
            end
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        alu_out_valid = 1'b0;
        ready_in      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_out   = '0;
        m_drop  = '0;
        m_stall = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", phv_out_valid); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
        checks++; if (phv_out !== '0) begin errors++; $display("FAIL reset_phv: got %h expected 0", phv_out); end
        checks++; if ({phv_out_cnt, phv_drop_cnt, stall_cnt} !== 96'd0) begin errors++; $display("FAIL reset_cnt: got %h/%h/%h expected 0", phv_out_cnt, phv_drop_cnt, stall_cnt); end
    endtask

    task automatic test_single();
        logic [PHV_LEN-1:0] b;
        do_reset();
        b = rnd_phv(1'b0);
        b[1023:976] = 48'h0000_1111_2222;
        b[271:256]  = 16'hBEEF;
        b[255:0]    = {32{8'h5A}};
        step(1'b1, b, 1'b1);
        checks++; if (phv_out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got valid %b expected 1", phv_out_valid); end
        checks++; if (phv_out[1023:976] !== 48'h0000_1111_2222) begin errors++; $display("FAIL single_6b7: got %h expected 000011112222", phv_out[1023:976]); end
        checks++; if (phv_out[271:256] !== 16'hBEEF) begin errors++; $display("FAIL single_2b0: got %h expected beef", phv_out[271:256]); end
        checks++; if (phv_out[255:0] !== {32{8'h5A}}) begin errors++; $display("FAIL single_meta: got %h expected 5a..", phv_out[255:0]); end
        checks++; if (phv_out !== b) begin errors++; $display("FAIL single_phv: got %h expected %h", phv_out, b); end
        step(1'b0, '0, 1'b1);
        checks++; if (phv_out_cnt !== 32'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", phv_out_cnt); end
        checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got valid %b expected 0", phv_out_valid); end
    endtask

    task automatic test_backpressure();
        logic [PHV_LEN-1:0] a, b, c;
        logic [PHV_LEN-1:0] got [$];
        bit c_done = 0;
        do_reset();
        a = rnd_phv(1'b0); b = rnd_phv(1'b0); c = rnd_phv(1'b0);
        step(1'b1, a, 1'b0);
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b expected 1", ready_out); end
        step(1'b1, b, 1'b0);
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready_b: got %b expected 0", ready_out); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, c, 1'b0);
            checks++; if (stall_cnt !== m_stall || ready_out !== 1'b0) begin errors++; $display("FAIL bp_stall: got %0d/%b expected %0d/0", stall_cnt, ready_out, m_stall); end
        end
        checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL bp_stall_total: got %0d expected 4", stall_cnt); end
        for (int i = 0; i < 8; i++) begin
            if (phv_out_valid) got.push_back(phv_out);
            if (!c_done) begin step(1'b1, c, 1'b1); c_done = last_acc; end
            else step(1'b0, '0, 1'b1);
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got.size()); end
        else begin
            checks++; if (got[0] !== a || got[1] !== b || got[2] !== c) begin errors++; $display("FAIL bp_order: got %h.. expected %h..", got[0][63:0], a[63:0]); end
        end
        checks++; if (phv_out_cnt !== 32'd3 || phv_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0d/%b expected 3/0", phv_out_cnt, phv_out_valid); end
    endtask

    task automatic test_discard();
        logic [PHV_LEN-1:0] x, d;
        do_reset();
        x = rnd_phv(1'b1); d = rnd_phv(1'b0);
        step(1'b1, x, 1'b1);
        checks++; if (phv_out_valid !== 1'b0 || phv_drop_cnt !== 32'd1) begin errors++; $display("FAIL discard_drop: got %b/%0d expected 0/1", phv_out_valid, phv_drop_cnt); end
        step(1'b1, d, 1'b1);
        checks++; if (phv_out !== d || phv_out_valid !== 1'b1) begin errors++; $display("FAIL discard_d: got %h expected %h", phv_out, d); end
        step(1'b0, '0, 1'b1);
        checks++; if (phv_out_cnt !== 32'd1 || phv_drop_cnt !== 32'd1) begin errors++; $display("FAIL discard_cnt: got %0d/%0d expected 1/1", phv_out_cnt, phv_drop_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [PHV_LEN-1:0] p [11];
        do_reset();
        for (int i = 0; i < 11; i++) p[i] = rnd_phv(1'b0);
        step(1'b1, p[0], 1'b1);
        for (int i = 1; i <= 10; i++) begin
            checks++; if (ready_out !== 1'b1 || phv_out_valid !== 1'b1 || phv_out !== p[i-1]) begin errors++; $display("FAIL steady_%0d: got %b/%b %h expected 1/1 %h", i, ready_out, phv_out_valid, phv_out[63:0], p[i-1][63:0]); end
            step(1'b1, p[i], 1'b1);
        end
        checks++; if (phv_out !== p[10] || phv_out_cnt !== 32'd10) begin errors++; $display("FAIL steady_end: got cnt %0d expected 10", phv_out_cnt); end
        step(1'b0, '0, 1'b1);
        checks++; if (phv_out_cnt !== 32'd11 || phv_out_valid !== 1'b0) begin errors++; $display("FAIL steady_drain: got %0d/%b expected 11/0", phv_out_cnt, phv_out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, rnd_phv(1'b0), 1'b1);
        step(1'b1, rnd_phv(1'b1), 1'b1);
        step(1'b1, rnd_phv(1'b0), 1'b0);
        step(1'b1, rnd_phv(1'b0), 1'b0);
        checks++; if (ready_out !== 1'b0 || phv_out_cnt !== 32'd1 || phv_drop_cnt !== 32'd1 || stall_cnt !== 32'd1) begin errors++; $display("FAIL mid_pre: got %b %0d %0d %0d expected 0 1 1 1", ready_out, phv_out_cnt, phv_drop_cnt, stall_cnt); end
        rst = 1'b1; alu_out_valid = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        rst = 1'b0; alu_out_valid = 1'b0;
        mq.delete(); m_out = '0; m_drop = '0; m_stall = '0;
        checks++; if (phv_out_valid !== 1'b0 || ready_out !== 1'b1 || phv_out !== '0) begin errors++; $display("FAIL mid_state: got %b/%b expected 0/1", phv_out_valid, ready_out); end
        checks++; if ({phv_out_cnt, phv_drop_cnt, stall_cnt} !== 96'd0) begin errors++; $display("FAIL mid_cnt: got %0d/%0d/%0d expected 0", phv_out_cnt, phv_drop_cnt, stall_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1'b1, rnd_phv(1'b0), 1'b0);
        step(1'b0, '0, 1'b0);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        m_stall = 32'hFFFF_FFFF;
        step(1'b0, '0, 1'b0);
        release dut.stall_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_stall: got %h expected ffffffff", stall_cnt); end
        end
    endtask

    task automatic test_random();
        logic [PHV_LEN-1:0] b;
        bit v;
        bit r;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            b = rnd_phv($urandom_range(0, 7) == 0);
            step(v, b, r);
            checks++; if (phv_out_valid !== (mq.size() != 0) || ready_out !== (mq.size() != 2)) begin errors++; $display("FAIL rand_flags_%0d: got %b/%b expected %b/%b", i, phv_out_valid, ready_out, mq.size() != 0, mq.size() != 2); end
            checks++; if (phv_out !== m_head()) begin errors++; $display("FAIL rand_phv_%0d: got %h expected %h", i, phv_out[63:0], m_head()); end
            checks++; if (phv_out_cnt !== m_out || phv_drop_cnt !== m_drop || stall_cnt !== m_stall) begin errors++; $display("FAIL rand_cnt_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i, phv_out_cnt, phv_drop_cnt, stall_cnt, m_out, m_drop, m_stall); end
        end
    endtask

    initial begin
        rst = 1'b1; alu_out_valid = 1'b0; ready_in = 1'b0;
        alu_out_6B = '0; alu_out_4B = '0; alu_out_2B = '0; phv_remain_data = '0;
        m_out = '0; m_drop = '0; m_stall = '0; last_acc = 0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_discard();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/phv_assembler.md
Name: phv_assembler

Overview:
- Return path of the action stage: collects per-container ALU results and the untouched metadata and repacks them into one PHV for the next stage.
- Mirrors the stage-entry crossbar, which splits a PHV into ALU operand buses. This block is the receiver/packer at the ALU output.
- Holds results in a 2-entry buffer so downstream backpressure never drops a PHV. Also honours the metadata discard flag and keeps statistics counters.

Parameters:
- STAGE_ID, 0, stage index; informational only.
- PHV_LEN, 1024, total PHV width (8×48 + 8×32 + 8×16 + 256).
- width_6B, 48, width of one 6B container.
- width_4B, 32, width of one 4B container.
- width_2B, 16, width of one 2B container.
- DISCARD_BIT, 128, bit index inside the 256-bit metadata that marks a PHV for discard.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  stage clock.
- rst  in  1  synchronous active-high reset.
- alu_out_valid  in  1  ALU results are valid this cycle.
- alu_out_6B  in  384  8×6B results; container 7 is at the MSBs.
- alu_out_4B  in  256  8×4B results; container 7 is at the MSBs.
- alu_out_2B  in  128  8×2B results; container 7 is at the MSBs.
- phv_remain_data  in  256  metadata, passed through unchanged.
- ready_out  out  1  block can accept a result this cycle.
- phv_out  out  PHV_LEN  reassembled PHV.
- phv_out_valid  out  1  phv_out is valid.
- ready_in  in  1  downstream accepts phv_out.
- phv_out_cnt  out  CNT_W  number of PHVs delivered.
- phv_drop_cnt  out  CNT_W  number of PHVs discarded.
- stall_cnt  out  CNT_W  cycles with phv_out_valid=1 and ready_in=0.

Behaviour:
- Packing: entry = {alu_out_6B, alu_out_4B, alu_out_2B, phv_remain_data}.
  - Field order is identical to the crossbar's input PHV layout.
  - The 6B field occupies [PHV_LEN-1 -: 384]; metadata occupies [255:0].
- Accept rule: accept = alu_out_valid & ready_out.
- ready_out = (count != 2). It is driven combinationally from registered state only, never from alu_out_valid or ready_in.
- Discard: an accepted beat with phv_remain_data[DISCARD_BIT]=1 is not written to the buffer and increments phv_drop_cnt. It still counts as accepted.
- Buffer:
  - 2-entry FIFO, registered, with wr_ptr, rd_ptr and count (0..2).
  - phv_out = mem[rd_ptr]; phv_out_valid = (count != 0).
- Pop rule: pop = phv_out_valid & ready_in.
- Latency: a kept beat accepted at cycle N appears on phv_out at N+1 when the buffer was empty. There is no combinational path from input to output.
- Simultaneous push and pop: with count=1 the count stays 1 and both pointers advance. With count=2 no push can occur because ready_out=0.
- Pointers are 1 bit and wrap 1→0.
- Order: PHVs leave in strict arrival order.
- Counters:
  - phv_out_cnt increments on pop.
  - stall_cnt increments on each cycle with phv_out_valid & ~ready_in.
  - All counters saturate at all-ones.
- Reset:
  - count, pointers and counters go to 0; phv_out_valid=0; ready_out=1; phv_out=0.
  - Buffer contents are don't-care after reset.
  - Reset mid-transfer discards buffered PHVs. Upstream must re-send them.
- alu_out_valid=1 while ready_out=0: the beat is ignored. The upstream crossbar holds its data until ready_out returns.

Decomposition:
- Shared package (rmt_pkg):
  - container widths and counts (8 per size);
  - PHV_LEN and the metadata width (256);
  - the DISCARD_BIT default;
  - the field-offset constants used by both the crossbar and this block.
- Sub-module phv_skid_fifo: 2-entry, parameterised data width, valid/ready on both sides, with count output.
- phv_assembler contains the packing, the discard filter and the counters.

Test Plan:
- Single PHV, ready_in=1:
  - Stimulus: 6B container 7=0x0000_1111_2222, 2B container 0=0xBEEF, metadata=0x5A repeated.
  - Required: phv_out_valid one cycle later; phv_out[1023:976]=0x000011112222; phv_out[271:256]=0xBEEF; phv_out[255:0] matches the metadata; phv_out_cnt=1.
- Backpressure:
  - Stimulus: ready_in=0 while 3 beats A, B, C are presented back-to-back.
  - Required: A and B are accepted; ready_out=0 after B; C is held by upstream; stall_cnt counts each held cycle. With ready_in=1 the outputs are A, B, C in order.
- Discard:
  - Stimulus: beat with metadata[128]=1, then a normal beat D.
  - Required: only D appears at the output; phv_drop_cnt=1; phv_out_cnt=1.
- Steady state:
  - Stimulus: count=1 with push and pop every cycle for 10 cycles.
  - Required: count stays 1, ready_out stays 1, 10 PHVs delivered in order.
- Reset mid-operation:
  - Stimulus: rst=1 for 1 cycle while count=2.
  - Required: next cycle phv_out_valid=0, ready_out=1, all counters=0.
- Counter saturation:
  - Stimulus: force stall_cnt to 0xFFFFFFFF, then hold a stall.
  - Required: stall_cnt remains 0xFFFFFFFF.
